// File: rtl/read_usb_wire_data.sv
// USB receive-side wire sampler: synchronises {D+,D-}, recovers mid-bit sample
// points at FS/LS rate, and hands samples downstream through a 4-entry FIFO.
module read_usb_wire_data #(
    parameter int FS_BIT_CLKS = 4,
    parameter int LS_BIT_CLKS = 32,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] RxBitsIn,
    input  logic       fullSpeedRate,
    input  logic       RxWireRdy,
    output logic [1:0] RxBitsOut,
    output logic       RxWireWEn,
    output logic       RxDataInTick,
    output logic       RxOverflow
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } out_state_t;

    localparam logic [2:0] FIFO_FULL = 3'(FIFO_DEPTH);

    logic [1:0] sync_meta_q, sync_meta_d;
    logic [1:0] sync_bits_q, sync_bits_d;
    logic [1:0] sync_prev_q, sync_prev_d;
    logic [4:0] samp_cnt_q, samp_cnt_d;
    logic [1:0] fifo_mem_q [0:3];
    logic [1:0] fifo_mem_d [0:3];
    logic [1:0] in_idx_q, in_idx_d;
    logic [1:0] out_idx_q, out_idx_d;
    logic [2:0] fifo_cnt_q, fifo_cnt_d;
    logic [1:0] bits_out_q, bits_out_d;
    logic       wen_q, wen_d;
    logic       tick_q, tick_d;
    logic       overflow_q, overflow_d;
    out_state_t state_q, state_d;

    logic [5:0] period;
    logic [5:0] half_point;
    logic [5:0] last_count;
    logic [5:0] cnt_ext;
    logic       line_edge;
    logic       strobe;
    logic       push;
    logic       pop;

    // Bit timing: the counter re-aligns on every line transition and the
    // sample point sits at the middle of the bit.
    always_comb begin
        period      = fullSpeedRate ? 6'(FS_BIT_CLKS) : 6'(LS_BIT_CLKS);
        half_point  = (period >> 1) - 6'd1;
        last_count  = period - 6'd1;
        cnt_ext     = {1'b0, samp_cnt_q};
        sync_meta_d = RxBitsIn;
        sync_bits_d = sync_meta_q;
        sync_prev_d = sync_bits_q;
        line_edge   = (sync_bits_q != sync_prev_q);
        strobe      = !line_edge && (cnt_ext == half_point);
        samp_cnt_d  = samp_cnt_q + 5'd1;
        if (line_edge || (cnt_ext >= last_count)) begin
            samp_cnt_d = 5'd0;
        end
    end

    always_comb begin
        pop        = (state_q == IDLE) && (fifo_cnt_q != 3'd0) && RxWireRdy;
        push       = strobe && (fifo_cnt_q != FIFO_FULL);
        overflow_d = strobe && (fifo_cnt_q == FIFO_FULL);
        tick_d     = tick_q ^ strobe;
        fifo_mem_d = fifo_mem_q;
        in_idx_d   = in_idx_q;
        out_idx_d  = out_idx_q;
        bits_out_d = bits_out_q;
        fifo_cnt_d = fifo_cnt_q;
        if (push) begin
            fifo_mem_d[in_idx_q] = sync_bits_q;
            in_idx_d             = in_idx_q + 2'd1;
        end
        if (pop) begin
            bits_out_d = fifo_mem_q[out_idx_q];
            out_idx_d  = out_idx_q + 2'd1;
        end
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 3'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 3'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // Output handshake spaces writes at least two cycles apart.
    always_comb begin
        state_d = state_q;
        wen_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    wen_d   = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta_q <= 2'b00;
            sync_bits_q <= 2'b00;
            sync_prev_q <= 2'b00;
            samp_cnt_q  <= 5'd0;
            for (int i = 0; i < 4; i++) begin
                fifo_mem_q[i] <= 2'b00;
            end
            in_idx_q    <= 2'd0;
            out_idx_q   <= 2'd0;
            fifo_cnt_q  <= 3'd0;
            bits_out_q  <= 2'b00;
            wen_q       <= 1'b0;
            tick_q      <= 1'b0;
            overflow_q  <= 1'b0;
            state_q     <= IDLE;
        end else begin
            sync_meta_q <= sync_meta_d;
            sync_bits_q <= sync_bits_d;
            sync_prev_q <= sync_prev_d;
            samp_cnt_q  <= samp_cnt_d;
            fifo_mem_q  <= fifo_mem_d;
            in_idx_q    <= in_idx_d;
            out_idx_q   <= out_idx_d;
            fifo_cnt_q  <= fifo_cnt_d;
            bits_out_q  <= bits_out_d;
            wen_q       <= wen_d;
            tick_q      <= tick_d;
            overflow_q  <= overflow_d;
            state_q     <= state_d;
        end
    end

    assign RxBitsOut    = bits_out_q;
    assign RxWireWEn    = wen_q;
    assign RxDataInTick = tick_q;
    assign RxOverflow   = overflow_q;

endmodule

// File: tb/tb_read_usb_wire_data.sv
// Directed bench for read_usb_wire_data: sequences of line states with
// hand-derived expected samples, overflow, reset and rate-switch timing.
module tb_read_usb_wire_data;

    logic       clk;
    logic       rst;
    logic [1:0] RxBitsIn;
    logic       fullSpeedRate;
    logic       RxWireRdy;
    logic [1:0] RxBitsOut;
    logic       RxWireWEn;
    logic       RxDataInTick;
    logic       RxOverflow;

    int assert_count;
    int fail_count;
    int cycle;
    int tick_count;
    int last_tick_cycle;
    int wen_count;
    int ovf_count;
    logic prev_tick;
    logic [1:0] captured [$];
    logic [1:0] seq_vals [$];
    int         seq_durs [$];

    read_usb_wire_data #(
        .FS_BIT_CLKS(4),
        .LS_BIT_CLKS(32),
        .FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .RxBitsIn     (RxBitsIn),
        .fullSpeedRate(fullSpeedRate),
        .RxWireRdy    (RxWireRdy),
        .RxBitsOut    (RxBitsOut),
        .RxWireWEn    (RxWireWEn),
        .RxDataInTick (RxDataInTick),
        .RxOverflow   (RxOverflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observe outputs 2 time units after each rising edge.
    always @(posedge clk) begin
        cycle = cycle + 1;
        #2;
        if (RxWireWEn) begin
            captured.push_back(RxBitsOut);
            wen_count = wen_count + 1;
        end
        if (RxOverflow) ovf_count = ovf_count + 1;
        if (RxDataInTick != prev_tick) begin
            tick_count      = tick_count + 1;
            last_tick_cycle = cycle;
        end
        prev_tick = RxDataInTick;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        assert_count = assert_count + 1;
        if (observed != expected) begin
            fail_count = fail_count + 1;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] bits, input int cycles);
        RxBitsIn = bits;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic doReset(input logic fs, input logic [1:0] bits, input logic rdy);
        rst           = 1'b1;
        fullSpeedRate = fs;
        RxBitsIn      = bits;
        RxWireRdy     = rdy;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic waitTicks(input int target, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (tick_count >= target) break;
            @(negedge clk);
        end
        checkOutput(tag, tick_count, target);
    endtask

    task automatic waitWen(input int target, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (wen_count >= target) break;
            @(negedge clk);
        end
        checkOutput(tag, wen_count, target);
    endtask

    // Idle SE0 samples are ignored; data bits are never 00.
    task automatic playAndCheck(input string tag, input int trailing);
        int q_start;
        int ov0;
        logic [1:0] got [$];
        q_start = captured.size();
        ov0     = ovf_count;
        for (int i = 0; i < seq_vals.size(); i++) begin
            applyStimulus(seq_vals[i], seq_durs[i]);
        end
        applyStimulus(2'b00, trailing);
        for (int i = q_start; i < captured.size(); i++) begin
            if (captured[i] != 2'b00) got.push_back(captured[i]);
        end
        checkOutput({tag, "_len"}, got.size(), seq_vals.size());
        for (int i = 0; i < seq_vals.size() && i < got.size(); i++) begin
            checkOutput($sformatf("%s_bit%0d", tag, i), int'(got[i]), int'(seq_vals[i]));
        end
        checkOutput({tag, "_no_ovf"}, ovf_count - ov0, 0);
    endtask

    initial begin
        int c0;
        int t0;
        int w0;
        int ov0;
        int q0;
        int stale;
        int ls_durs [8];
        logic [1:0] ls_vals [8];
        logic [1:0] wrap_vals [10];

        assert_count    = 0;
        fail_count      = 0;
        cycle           = 0;
        tick_count      = 0;
        last_tick_cycle = 0;
        wen_count       = 0;
        ovf_count       = 0;
        prev_tick       = 1'b0;
        rst             = 1'b1;
        RxBitsIn        = 2'b00;
        fullSpeedRate   = 1'b1;
        RxWireRdy       = 1'b1;

        repeat (2) @(negedge clk);
        checkOutput("rst_bits_out", int'(RxBitsOut), 0);
        checkOutput("rst_wen", int'(RxWireWEn), 0);
        checkOutput("rst_tick", int'(RxDataInTick), 0);
        checkOutput("rst_ovf", int'(RxOverflow), 0);

        $display("[TB] FS steady alternating stream");
        doReset(1'b1, 2'b00, 1'b1);
        repeat (10) @(negedge clk);
        seq_vals.delete();
        seq_durs.delete();
        for (int i = 0; i < 12; i++) begin
            seq_vals.push_back((i % 2 == 0) ? 2'b10 : 2'b01);
            seq_durs.push_back(4);
        end
        playAndCheck("fs", 16);

        $display("[TB] FS mixed stream with pointer wrap");
        wrap_vals = '{2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01};
        seq_vals.delete();
        seq_durs.delete();
        for (int i = 0; i < 10; i++) begin
            seq_vals.push_back(wrap_vals[i]);
            seq_durs.push_back(4);
        end
        playAndCheck("wrap", 16);

        $display("[TB] LS stream with edge jitter");
        doReset(1'b0, 2'b00, 1'b1);
        repeat (40) @(negedge clk);
        ls_vals = '{2'b10, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01};
        ls_durs = '{35, 26, 38, 29, 29, 38, 26, 35};
        seq_vals.delete();
        seq_durs.delete();
        for (int i = 0; i < 8; i++) begin
            seq_vals.push_back(ls_vals[i]);
            seq_durs.push_back(ls_durs[i]);
        end
        playAndCheck("ls", 80);

        $display("[TB] overflow with downstream stalled");
        doReset(1'b1, 2'b10, 1'b1);
        repeat (12) @(negedge clk);
        waitWen(wen_count + 1, 12, "ovf_drain_wen");
        RxWireRdy = 1'b0;
        t0  = tick_count;
        w0  = wen_count;
        ov0 = ovf_count;
        waitTicks(t0 + 4, 30, "ovf_four_strobes");
        checkOutput("ovf_none_before_full", ovf_count - ov0, 0);
        waitTicks(t0 + 6, 20, "ovf_six_strobes");
        checkOutput("ovf_two_pulses", ovf_count - ov0, 2);
        checkOutput("ovf_no_wen_stalled", wen_count - w0, 0);
        RxWireRdy = 1'b1;
        w0 = wen_count;
        q0 = captured.size();
        repeat (8) @(negedge clk);
        checkOutput("ovf_four_outputs", wen_count - w0, 4);
        for (int i = q0; i < q0 + 4 && i < captured.size(); i++) begin
            checkOutput($sformatf("ovf_out%0d", i - q0), int'(captured[i]), 2);
        end

        $display("[TB] asynchronous reset with three entries buffered");
        doReset(1'b1, 2'b10, 1'b1);
        repeat (12) @(negedge clk);
        waitWen(wen_count + 1, 12, "arst_drain_wen");
        RxWireRdy = 1'b0;
        waitTicks(tick_count + 3, 20, "arst_three_strobes");
        checkOutput("arst_pre_bits", int'(RxBitsOut), 2);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_bits_out", int'(RxBitsOut), 0);
        checkOutput("arst_wen", int'(RxWireWEn), 0);
        checkOutput("arst_tick", int'(RxDataInTick), 0);
        checkOutput("arst_ovf", int'(RxOverflow), 0);
        @(negedge clk);
        rst       = 1'b0;
        RxBitsIn  = 2'b00;
        RxWireRdy = 1'b1;
        w0 = wen_count;
        q0 = captured.size();
        repeat (2) @(negedge clk);
        checkOutput("arst_no_early_wen", wen_count - w0, 0);
        waitWen(w0 + 1, 10, "arst_first_wen");
        repeat (20) @(negedge clk);
        stale = 0;
        for (int i = q0; i < captured.size(); i++) begin
            if (captured[i] != 2'b00) stale = stale + 1;
        end
        checkOutput("arst_no_stale_samples", stale, 0);

        $display("[TB] rate switch FS to LS mid-bit");
        doReset(1'b1, 2'b00, 1'b1);
        repeat (10) @(negedge clk);
        c0 = cycle;
        applyStimulus(2'b10, 5);
        checkOutput("rate_fs_strobe", last_tick_cycle - c0, 5);
        applyStimulus(2'b10, 1);
        fullSpeedRate = 1'b0;
        waitTicks(tick_count + 1, 40, "rate_first_ls_tick");
        checkOutput("rate_ls_strobe1", last_tick_cycle - c0, 19);
        waitTicks(tick_count + 1, 40, "rate_second_ls_tick");
        checkOutput("rate_ls_strobe2", last_tick_cycle - c0, 51);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
